// File: rtl/mem_loader_if.sv
// Source-side word stream into the memory loader: valid/data from the source, ready back from the loader.
interface mem_loader_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/mem_loader.sv
// Streams K, W1 and W2 words from a valid/ready source into three single-port memories
// sharing one address/data bus, issuing each write one cycle after the word is accepted.
module mem_loader #(
  parameter int NUM_ADDR = 5,
  parameter int K_WORDS  = 2,
  parameter int W1_WORDS = 8,
  parameter int W2_WORDS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                learn,
  mem_loader_if.slave         src,
  output logic                busy,
  output logic                done,
  output logic [NUM_ADDR-1:0] MEM_A,
  output logic [31:0]         MEM_IDATA,
  output logic                MEM_WEB,
  output logic                MEM_OEB,
  output logic                KMEM_CSB,
  output logic                W1MEM_CSB,
  output logic                W2MEM_CSB
);

  typedef enum logic [2:0] {IDLE, LOAD_K, LOAD_W1, LOAD_W2, DONE} state_e;

  localparam logic [NUM_ADDR-1:0] K_LAST  = NUM_ADDR'(K_WORDS - 1);
  localparam logic [NUM_ADDR-1:0] W1_LAST = NUM_ADDR'(W1_WORDS - 1);
  localparam logic [NUM_ADDR-1:0] W2_LAST = NUM_ADDR'(W2_WORDS - 1);

  state_e              state_q, state_d, region_next;
  logic [NUM_ADDR-1:0] cnt_q, cnt_d;
  logic [NUM_ADDR-1:0] mem_a_q;
  logic [31:0]         mem_idata_q;
  logic                web_q, kcsb_q, w1csb_q, w2csb_q;
  logic                busy_q, done_q;
  logic                accept, last;

  assign src.in_ready = (state_q == LOAD_K) || (state_q == LOAD_W1) || (state_q == LOAD_W2);
  assign accept       = src.in_ready && src.in_valid;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    last        = 1'b0;
    region_next = IDLE;
    unique case (state_q)
      IDLE: begin
        if (learn) begin
          state_d = LOAD_K;
          cnt_d   = '0;
        end
      end
      LOAD_K: begin
        last        = (cnt_q == K_LAST);
        region_next = LOAD_W1;
      end
      LOAD_W1: begin
        last        = (cnt_q == W1_LAST);
        region_next = LOAD_W2;
      end
      LOAD_W2: begin
        last        = (cnt_q == W2_LAST);
        region_next = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The last word of a region hands over to the next region on the same edge, so no bubble.
    if (accept) begin
      if (last) begin
        cnt_d   = '0;
        state_d = region_next;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the bus registers are reset too, so the memories see a defined idle bus after reset.
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_a_q     <= '0;
      mem_idata_q <= '0;
      web_q       <= 1'b1;
      kcsb_q      <= 1'b1;
      w1csb_q     <= 1'b1;
      w2csb_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      web_q   <= !accept;
      kcsb_q  <= !(accept && state_q == LOAD_K);
      w1csb_q <= !(accept && state_q == LOAD_W1);
      w2csb_q <= !(accept && state_q == LOAD_W2);
      busy_q  <= (state_d != IDLE);
      done_q  <= accept && last && (state_q == LOAD_W2);
      if (accept) begin
        mem_a_q     <= cnt_q;
        mem_idata_q <= src.in_data;
      end
    end
  end

  assign MEM_A     = mem_a_q;
  assign MEM_IDATA = mem_idata_q;
  assign MEM_WEB   = web_q;
  assign MEM_OEB   = 1'b1;
  assign KMEM_CSB  = kcsb_q;
  assign W1MEM_CSB = w1csb_q;
  assign W2MEM_CSB = w2csb_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: a default-sized instance and a K_WORDS=32 instance share one stimulus;
// a monitor logs every write strobe, and the directed steps compare the logs against hand-built expectations.
module tb_mem_loader;

  typedef struct {
    int          cyc;
    logic [2:0]  csb;   // {KMEM_CSB, W1MEM_CSB, W2MEM_CSB}
    logic [4:0]  addr;
    logic [31:0] data;
    logic        done;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst, learn, in_valid;
  logic [31:0] in_data;

  logic        a_busy, a_done, a_web, a_oeb, a_kcsb, a_w1csb, a_w2csb;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_busy, b_done, b_web, b_oeb, b_kcsb, b_w1csb, b_w2csb;
  logic [4:0]  b_addr;
  logic [31:0] b_data;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  done_a   = 0;
  int  done_b   = 0;
  int  bad_a    = 0;
  int  bad_b    = 0;
  bit  armed    = 1'b0;
  wr_t log_a[$];
  wr_t log_b[$];

  mem_loader_if if_a ();
  mem_loader_if if_b ();
  assign if_a.in_valid = in_valid;
  assign if_a.in_data  = in_data;
  assign if_b.in_valid = in_valid;
  assign if_b.in_data  = in_data;

  mem_loader dut_a (
    .clk(clk), .rst(rst), .learn(learn), .src(if_a.slave),
    .busy(a_busy), .done(a_done), .MEM_A(a_addr), .MEM_IDATA(a_data),
    .MEM_WEB(a_web), .MEM_OEB(a_oeb),
    .KMEM_CSB(a_kcsb), .W1MEM_CSB(a_w1csb), .W2MEM_CSB(a_w2csb)
  );

  mem_loader #(.NUM_ADDR(5), .K_WORDS(32), .W1_WORDS(2), .W2_WORDS(1)) dut_b (
    .clk(clk), .rst(rst), .learn(learn), .src(if_b.slave),
    .busy(b_busy), .done(b_done), .MEM_A(b_addr), .MEM_IDATA(b_data),
    .MEM_WEB(b_web), .MEM_OEB(b_oeb),
    .KMEM_CSB(b_kcsb), .W1MEM_CSB(b_w1csb), .W2MEM_CSB(b_w2csb)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  // Write monitor: samples 2 time units after each rising edge.
  always @(posedge clk) begin
    logic [2:0] ca, cb;
    cyc++;
    #2;
    if (armed) begin
      ca = {a_kcsb, a_w1csb, a_w2csb};
      cb = {b_kcsb, b_w1csb, b_w2csb};
      if (a_web === 1'b0) log_a.push_back('{cyc, ca, a_addr, a_data, a_done});
      if (b_web === 1'b0) log_b.push_back('{cyc, cb, b_addr, b_data, b_done});
      if (a_done === 1'b1) done_a++;
      if (b_done === 1'b1) done_b++;
      if ($countones(~ca) > 1 || (a_web !== (ca == 3'b111)) || (a_done && a_web) || a_oeb !== 1'b1) bad_a++;
      if ($countones(~cb) > 1 || (b_web !== (cb == 3'b111)) || (b_done && b_web) || b_oeb !== 1'b1) bad_b++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; learn = 1'b0; in_valid = 1'b0; in_data = '0;
    step();
    rst = 1'b0;
    log_a.delete(); log_b.delete();
    done_a = 0; done_b = 0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_mem_a"},  32'(a_addr), 32'h0);
    check({tag, "_idata"},  a_data, 32'h0);
    check({tag, "_web"},    32'(a_web), 32'h1);
    check({tag, "_oeb"},    32'(a_oeb), 32'h1);
    check({tag, "_csbs"},   32'({a_kcsb, a_w1csb, a_w2csb}), 32'h7);
    check({tag, "_ready"},  32'(if_a.in_ready), 32'h0);
    check({tag, "_busy"},   32'(a_busy), 32'h0);
    check({tag, "_done"},   32'(a_done), 32'h0);
  endtask

  task automatic pulse_learn();
    learn = 1'b1;
    step();
    learn = 1'b0;
  endtask

  // Default sizes: index 0..1 -> KMEM, 2..9 -> W1MEM, 10..17 -> W2MEM; data = index + 1.
  task automatic check_log_a(input string tag, input bit contig);
    logic [2:0] ecsb;
    int         eaddr;
    check({tag, "_writes"}, 32'(log_a.size()), 32'd18);
    if (log_a.size() == 18) begin
      for (int i = 0; i < 18; i++) begin
        if (i < 2)       begin ecsb = 3'b011; eaddr = i;      end
        else if (i < 10) begin ecsb = 3'b101; eaddr = i - 2;  end
        else             begin ecsb = 3'b110; eaddr = i - 10; end
        check($sformatf("%s_csb%0d", tag, i),  32'(log_a[i].csb), 32'(ecsb));
        check($sformatf("%s_addr%0d", tag, i), 32'(log_a[i].addr), 32'(eaddr));
        check($sformatf("%s_data%0d", tag, i), log_a[i].data, 32'(i + 1));
        check($sformatf("%s_done%0d", tag, i), 32'(log_a[i].done), 32'(i == 17));
        if (contig && i > 0)
          check($sformatf("%s_gap%0d", tag, i), 32'(log_a[i].cyc - log_a[i-1].cyc), 32'd1);
      end
    end
    check({tag, "_done_pulses"}, 32'(done_a), 32'd1);
  endtask

  initial begin
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int w;

    rst = 1'b1; learn = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) step();
    armed = 1'b1;
    check_reset_a("por");
    check("por_b_web", 32'(b_web), 32'h1);
    check("por_b_busy", 32'(b_busy), 32'h0);
    rst = 1'b0;

    // in_valid while IDLE must not be accepted.
    do_reset();
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    repeat (3) step();
    in_valid = 1'b0;
    check("idle_writes", 32'(log_a.size()), 32'd0);
    check("idle_ready", 32'(if_a.in_ready), 32'h0);
    check("idle_busy", 32'(a_busy), 32'h0);

    // Back-to-back load with default sizes.
    do_reset();
    pulse_learn();
    check("b2b_busy_start", 32'(a_busy), 32'h1);
    check("b2b_ready_start", 32'(if_a.in_ready), 32'h1);
    for (int i = 1; i <= 18; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      step();
    end
    in_valid = 1'b0;
    check("b2b_done_last", 32'(a_done), 32'h1);
    check("b2b_busy_done", 32'(a_busy), 32'h1);
    check("b2b_w2_addr7", 32'(a_addr), 32'h7);
    step();
    check("b2b_busy_after", 32'(a_busy), 32'h0);
    check("b2b_done_after", 32'(a_done), 32'h0);
    check("b2b_ready_after", 32'(if_a.in_ready), 32'h0);
    step();
    check_log_a("b2b", 1'b1);
    if (log_a.size() == 18) begin
      check("bound_k_last", 32'({log_a[1].csb, log_a[1].addr}), 32'({3'b011, 5'd1}));
      check("bound_w1_first", 32'({log_a[2].csb, log_a[2].addr}), 32'({3'b101, 5'd0}));
      check("bound_consec", 32'(log_a[2].cyc - log_a[1].cyc), 32'd1);
    end

    // Stalled source: valid pattern 1,0,0,1,0,1,1, then held high.
    do_reset();
    pulse_learn();
    w = 1;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      in_data  = pat[i] ? 32'(w) : 32'hBAD0_0000 | 32'(i);
      if (pat[i]) w++;
      step();
      check($sformatf("stall_ready%0d", i), 32'(if_a.in_ready), 32'h1);
    end
    while (w <= 18) begin
      in_valid = 1'b1; in_data = 32'(w); w++;
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    check_log_a("stall", 1'b0);
    if (log_a.size() == 18) begin
      check("stall_gap01", 32'(log_a[1].cyc - log_a[0].cyc), 32'd3);
      check("stall_gap12", 32'(log_a[2].cyc - log_a[1].cyc), 32'd2);
      check("stall_gap23", 32'(log_a[3].cyc - log_a[2].cyc), 32'd1);
    end

    // Mid-load reset on the edge that accepts the 5th word.
    do_reset();
    pulse_learn();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      step();
    end
    in_data = 32'd5; rst = 1'b1;
    step();
    in_valid = 1'b0;
    check_reset_a("midrst");
    check("midrst_writes", 32'(log_a.size()), 32'd4);
    rst = 1'b0;
    step();
    check("midrst_no_strobe", 32'(log_a.size()), 32'd4);
    log_a.delete(); done_a = 0;
    pulse_learn();
    for (int i = 1; i <= 18; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    check_log_a("restart", 1'b1);

    // learn pulsed while in LOAD_W1 (the 5th accepted word) is ignored.
    do_reset();
    pulse_learn();
    for (int i = 1; i <= 18; i++) begin
      in_valid = 1'b1; in_data = 32'(i); learn = (i == 5);
      step();
    end
    in_valid = 1'b0; learn = 1'b0;
    repeat (3) step();
    check_log_a("busylearn", 1'b1);
    check("busylearn_idle", 32'(a_busy), 32'h0);

    // Full-size KMEM region on the K_WORDS=32 instance.
    do_reset();
    pulse_learn();
    for (int i = 0; i < 35; i++) begin
      in_valid = 1'b1; in_data = 32'(100 + i);
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();
    check("k32_writes", 32'(log_b.size()), 32'd35);
    if (log_b.size() == 35) begin
      for (int i = 0; i < 35; i++) begin
        logic [2:0] ecsb;
        int         eaddr;
        if (i < 32)       begin ecsb = 3'b011; eaddr = i;      end
        else if (i < 34)  begin ecsb = 3'b101; eaddr = i - 32; end
        else              begin ecsb = 3'b110; eaddr = 0;      end
        check($sformatf("k32_csb%0d", i), 32'(log_b[i].csb), 32'(ecsb));
        check($sformatf("k32_addr%0d", i), 32'(log_b[i].addr), 32'(eaddr));
        check($sformatf("k32_data%0d", i), log_b[i].data, 32'(100 + i));
        if (i > 0) check($sformatf("k32_gap%0d", i), 32'(log_b[i].cyc - log_b[i-1].cyc), 32'd1);
      end
      check("k32_done_flag", 32'(log_b[34].done), 32'h1);
    end
    check("k32_done_pulses", 32'(done_b), 32'd1);
    check("k32_busy_after", 32'(b_busy), 32'h0);

    check("a_bus_rules", 32'(bad_a), 32'd0);
    check("b_bus_rules", 32'(bad_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
